// File: rtl/glip_demo_pkg.sv
// Shared encodings for the GLIP demo traffic generator/checker: operating modes,
// checker FSM states and the LFSR feedback tap mask.
package glip_demo_pkg;

    localparam logic [1:0] MODE_LOOPBACK = 2'b00;
    localparam logic [1:0] MODE_GEN      = 2'b01;
    localparam logic [1:0] MODE_CHECK    = 2'b10;
    localparam logic [1:0] MODE_GENCHECK = 2'b11;

    localparam logic [0:0] ST_SYNC  = 1'b0;
    localparam logic [0:0] ST_CHECK = 1'b1;

    // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/glip_demo_pattern_next.sv
// Combinational successor of one pattern byte; GLIP_DEMO_TRAFFIC_LFSR_EN selects a
// maximal-length 8-bit Fibonacci LFSR instead of the default modulo-256 incrementer.
module glip_demo_pattern_next
    import glip_demo_pkg::*;
(
    input  logic [7:0] cur,
    output logic [7:0] nxt
);

`ifdef GLIP_DEMO_TRAFFIC_LFSR_EN
    always_comb nxt = {cur[6:0], ^(cur & LFSR_TAPS)};
`else
    always_comb nxt = cur + 8'd1;
`endif

endmodule

// File: rtl/glip_demo_traffic.sv
// Byte-stream loopback / pattern generator / pattern checker for the GLIP UART demos.
// Pattern function selectable with GLIP_DEMO_TRAFFIC_LFSR_EN (see glip_demo_pattern_next).
module glip_demo_traffic
    import glip_demo_pkg::*;
#(
    parameter int         ERRCNT_WIDTH = 16,
    parameter logic [7:0] SEED         = 8'h01
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [1:0]              mode,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    error,
    output logic                    error_sticky,
    output logic [ERRCNT_WIDTH-1:0] err_count,
    output logic                    synced
);

    logic [1:0]              mode_q, mode_d;
    logic [7:0]              tx_q, tx_d;
    logic [7:0]              exp_q, exp_d;
    logic [0:0]              state_q, state_d;
    logic                    error_q, error_d;
    logic                    sticky_q, sticky_d;
    logic [ERRCNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [7:0] tx_next, chk_next;
    logic       gen_en, chk_en, out_hs, in_hs, mode_chg;

    function automatic logic [ERRCNT_WIDTH-1:0] sat_inc(input logic [ERRCNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(ERRCNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    glip_demo_pattern_next u_gen_next (.cur(tx_q),    .nxt(tx_next));
    glip_demo_pattern_next u_chk_next (.cur(in_data), .nxt(chk_next));

    always_comb begin
        gen_en = mode_q[0];
        chk_en = mode_q[1];
        if (mode_q == MODE_LOOPBACK) begin
            out_data  = in_data;
            out_valid = in_valid;
            in_ready  = out_ready;
        end else begin
            out_data  = gen_en ? tx_q : 8'h00;
            out_valid = gen_en;
            in_ready  = chk_en;
        end
    end

    always_comb begin
        out_hs   = out_valid && out_ready;
        in_hs    = chk_en && in_valid;
        // Hold the mode while an outbound byte is stalled so it is never altered.
        mode_d   = (out_valid && !out_ready) ? mode_q : mode;
        mode_chg = (mode_d != mode_q);

        tx_d     = tx_q;
        exp_d    = exp_q;
        state_d  = state_q;
        error_d  = 1'b0;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        if (gen_en && out_hs) tx_d = tx_next;

        // A mismatch resynchronises on the received byte rather than the expected one.
        if (in_hs) begin
            exp_d   = chk_next;
            state_d = ST_CHECK;
            if ((state_q == ST_CHECK) && (in_data != exp_q)) begin
                error_d  = 1'b1;
                sticky_d = 1'b1;
                cnt_d    = sat_inc(cnt_q);
            end
        end

        if (mode_chg) begin
            tx_d    = SEED;
            state_d = ST_SYNC;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q   <= MODE_LOOPBACK;
            tx_q     <= SEED;
            exp_q    <= 8'h00;
            state_q  <= ST_SYNC;
            error_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            tx_q     <= tx_d;
            exp_q    <= exp_d;
            state_q  <= state_d;
            error_q  <= error_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign error        = error_q;
    assign error_sticky = sticky_q;
    assign err_count    = cnt_q;
    assign synced       = (state_q == ST_CHECK);

endmodule

// File: tb/tb_glip_demo_traffic.sv
// Scoreboard bench for glip_demo_traffic: randomized stimulus, queue-based expectations.
`timescale 1ns/1ps
module tb_glip_demo_traffic;
    import glip_demo_pkg::*;

    localparam logic [7:0] SEED = 8'h01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [1:0]  mode;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        error;
    logic        error_sticky;
    logic [15:0] err_count;
    logic        synced;

    logic [1:0]  s_mode;
    logic [7:0]  s_in_data;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_out_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic        s_error;
    logic        s_sticky;
    logic [1:0]  s_cnt;
    logic        s_synced;

    glip_demo_traffic #(.ERRCNT_WIDTH(16), .SEED(SEED)) dut (
        .clk(clk), .rstn(rstn), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .error(error), .error_sticky(error_sticky), .err_count(err_count), .synced(synced)
    );

    glip_demo_traffic #(.ERRCNT_WIDTH(2), .SEED(SEED)) u_sat (
        .clk(clk), .rstn(rstn), .mode(s_mode),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .error(s_error), .error_sticky(s_sticky), .err_count(s_cnt), .synced(s_synced)
    );

    typedef struct {
        logic err;
        int   cnt;
        logic sticky;
    } exp_t;

    int         n_chk = 0;
    int         n_err = 0;
    logic [1:0] mon_mode = MODE_LOOPBACK;
    logic       chk_pending = 1'b0;
    logic [7:0] gen_val = SEED;
    logic       m_sync = 1'b0;
    logic       m_sticky = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_exp = 8'h00;
    logic [7:0] gen_q[$];
    exp_t       chk_q[$];
    exp_t       mon_e;

    function automatic logic [7:0] next8(input logic [7:0] v);
`ifdef GLIP_DEMO_TRAFFIC_LFSR_EN
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`else
        return v + 8'd1;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues on the falling edge.
    always @(negedge clk) begin
        if (!rstn) begin
            chk_pending = 1'b0;
        end else begin
            if (chk_pending) begin
                chk_pending = 1'b0;
                if (chk_q.size() == 0) begin
                    check("chk_underflow", 1, 0);
                end else begin
                    mon_e = chk_q.pop_front();
                    check("error", error, mon_e.err);
                    check("err_count", err_count, mon_e.cnt);
                    check("error_sticky", error_sticky, mon_e.sticky);
                    check("synced", synced, 1);
                end
            end else begin
                check("error_idle", error, 0);
            end
            case (mon_mode)
                MODE_LOOPBACK: begin
                    check("lb_data", out_data, in_data);
                    check("lb_valid", out_valid, in_valid);
                    check("lb_ready", in_ready, out_ready);
                end
                MODE_CHECK: begin
                    check("chk_out_valid", out_valid, 0);
                    check("chk_out_data", out_data, 0);
                end
                default: begin
                    check("gen_valid", out_valid, 1);
                    if (out_ready) begin
                        if (gen_q.size() == 0) check("gen_underflow", 1, 0);
                        else check("gen_data", out_data, gen_q.pop_front());
                    end else begin
                        check("gen_hold", out_data, gen_val);
                    end
                end
            endcase
            if (mon_mode[1]) begin
                check("chk_in_ready", in_ready, 1);
                if (in_valid) chk_pending = 1'b1;
            end else if (mon_mode == MODE_GEN) begin
                check("gen_in_ready", in_ready, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode     = m;
        in_valid = 1'b0;
        if (mon_mode[0]) begin
            out_ready = 1'b1;
            gen_q.push_back(gen_val);
            gen_val = next8(gen_val);
        end else begin
            out_ready = 1'b0;
        end
        step();
        if (m != mon_mode) begin
            gen_val = SEED;
            m_sync  = 1'b0;
        end
        mon_mode  = m;
        out_ready = 1'b0;
    endtask

    task automatic run_gen(input int n);
        int sent = 0;
        int cyc  = 0;
        while (sent < n && cyc < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_ready) begin
                gen_q.push_back(gen_val);
                gen_val = next8(gen_val);
                sent++;
            end
            step();
            cyc++;
        end
        if (sent < n) check("gen_budget", sent, n);
        out_ready = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        exp_t e;
        if (!m_sync) begin
            m_sync = 1'b1;
            e.err  = 1'b0;
        end else begin
            e.err = (d != m_exp);
        end
        m_exp = next8(d);
        if (e.err) begin
            m_sticky = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end
        e.cnt    = m_cnt;
        e.sticky = m_sticky;
        chk_q.push_back(e);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic rand_stream(input int n);
        logic [7:0] d;
        d = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            send_byte(d);
            d = ($urandom_range(0, 5) == 0) ? 8'($urandom) : next8(d);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic s_send(input logic [7:0] d);
        s_in_data  = d;
        s_in_valid = 1'b1;
        step();
        s_in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_sticky"}, error_sticky, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_synced"}, synced, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn        = 1'b0;
        mode        = MODE_LOOPBACK;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        s_mode      = MODE_CHECK;
        s_in_data   = 8'h00;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b0;
        #2;
        check_reset_outputs("rst");
        step();
        step();
        rstn = 1'b1;
        step();

        // Saturating counter on the 2-bit instance: sync, then five mismatches.
        s_send(8'h10);
        check("sat_synced", s_synced, 1);
        for (int k = 1; k <= 5; k++) begin
            s_send(8'(8'h10 + 8'h20 * k));
            check("sat_error", s_error, 1);
            check("sat_count", s_cnt, (k < 3) ? k : 3);
        end
        check("sat_sticky", s_sticky, 1);
        check("sat_out_valid", s_out_valid, 0);

        // Loopback: directed bytes, backpressure, then random traffic.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        step();
        in_data = 8'h22;
        step();
        out_ready = 1'b0;
        step();
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Generator with random backpressure, long enough to pass the FF->00 wrap.
        set_mode(MODE_GEN);
        run_gen(260);

        // Mode change requested while stalled must wait for the handshake.
        mode = MODE_CHECK;
        repeat (3) step();
        set_mode(MODE_CHECK);

        for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i));
        set_mode(MODE_LOOPBACK);
        set_mode(MODE_CHECK);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h09);
        send_byte(8'h0A);
        send_byte(8'hFE);
        send_byte(8'hFF);
        send_byte(8'h00);
        rand_stream(40);

        set_mode(MODE_GENCHECK);
        fork
            run_gen(40);
            rand_stream(30);
        join

        // Asynchronous reset while an outbound byte is stalled.
        set_mode(MODE_GEN);
        step();
        step();
        rstn = 1'b0;
        mode = MODE_LOOPBACK;
        #1;
        check_reset_outputs("mid_rst");
        mon_mode = MODE_LOOPBACK;
        gen_val  = SEED;
        m_sync   = 1'b0;
        m_sticky = 1'b0;
        m_cnt    = 0;
        gen_q.delete();
        chk_q.delete();
        step();
        rstn = 1'b1;
        step();

        set_mode(MODE_GENCHECK);
        fork
            run_gen(12);
            rand_stream(10);
        join
        set_mode(MODE_LOOPBACK);
        step();
        step();
        check("gen_q_drained", gen_q.size(), 0);
        check("chk_q_drained", chk_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/glip_demo_traffic.md
# glip_demo_traffic

Byte-stream traffic generator and checker for the GLIP UART board demos. It sits directly on the logic-side FIFO interface of the UART backend: it consumes the inbound byte stream and produces the outbound byte stream. Selectable modes are loopback, pattern generation, pattern checking, or simultaneous generation and checking. Checker results (sticky error, saturating error count, sync flag) drive board LEDs and the seven-segment measurement path.

## Interface

Parameters:
- `ERRCNT_WIDTH`, default 16: width of the saturating mismatch counter.
- `SEED`, default 8'h01: first pattern value after reset or mode entry. Must be non-zero when the LFSR option is enabled.

Ports:
- `clk` in 1: single clock; all logic is synchronous to it.
- `rstn` in 1: reset, asynchronous and active-low.
- `mode` in 2: 00 loopback, 01 generate, 10 check, 11 generate+check. Quasi-static (switches).
- `in_data` in 8: inbound byte from the backend FIFO.
- `in_valid` in 1: inbound byte valid.
- `in_ready` out 1: block accepts the inbound byte.
- `out_data` out 8: outbound byte to the backend FIFO.
- `out_valid` out 1: outbound byte valid.
- `out_ready` in 1: backend accepts the outbound byte.
- `error` out 1: one-cycle pulse on a checker mismatch.
- `error_sticky` out 1: set by any mismatch; cleared only by reset.
- `err_count` out ERRCNT_WIDTH: number of mismatches, saturating at all-ones.
- `synced` out 1: checker has locked to the stream.

## Operation

- **Mode register.** `mode_q` is loaded from `mode` on any cycle except when `out_valid && !out_ready` (a stalled outbound byte must stay stable).
  - Resets to 00.
  - On any change of `mode_q`: generator value returns to SEED, and the checker returns to SYNC.
- **Loopback (00).** Purely combinational path: `out_data = in_data`, `out_valid = in_valid`, `in_ready = out_ready`. Generator and checker are idle.
- **Generator (01, 11).**
  - `out_valid = 1` and `out_data = tx_q`.
  - On the handshake (`out_valid && out_ready`), `tx_q <= next(tx_q)`.
  - In mode 01, `in_ready = 0`.
- **Checker (10, 11).**
  - `in_ready = 1`; every inbound byte is consumed.
  - In mode 10, `out_valid = 0` and `out_data = 0`.
  - The FSM has two states:
    - **SYNC:** on an accepted byte d, set `exp_q <= next(d)`, go to CHECK, and set `synced`.
    - **CHECK:** on an accepted byte d:
      - If d == exp_q: `exp_q <= next(d)`.
      - Otherwise: pulse `error`, set `error_sticky`, increment `err_count` (saturating), then resynchronise with `exp_q <= next(d)` and stay in CHECK.
- **Pattern function `next()`.**
  - Default: increment modulo 256, so 8'hFF wraps to 8'h00.
  - With the LFSR option: see Configuration.

## Timing

- Reset values:
  - `mode_q` = 00, `tx_q` = SEED, `exp_q` = 0, FSM = SYNC.
  - `error`, `error_sticky`, `synced`, `err_count` = 0.
  - `out_valid`/`in_ready` follow loopback, so they are 0 while `in_valid`/`out_ready` are 0.
- Loopback has zero latency (combinational).
- The generator presents SEED in the cycle after `mode_q` becomes 01/11. Sustained throughput is one byte per cycle while `out_ready = 1`.
- `error`, `err_count`, `error_sticky` and `synced` are registered. They update on the edge that completes the mismatching (or first) handshake and are visible one cycle later.
- `err_count` at all-ones remains all-ones on further mismatches; `error` still pulses.
- A mode change requested during an outbound stall is deferred until the handshake completes. No outbound byte is ever withdrawn or altered while stalled.
- Asserting `rstn` low mid-stream forces all reset values immediately (asynchronously). A partially presented outbound byte is dropped.

## Configuration

- `GLIP_DEMO_TRAFFIC_LFSR_EN`:
  - **Defined:** `next()` is an 8-bit Fibonacci LFSR with polynomial x^8+x^6+x^5+x^4+1 (period 255, never produces 0). The generator and checker both use it.
  - **Undefined:** `next()` is a plain incrementer.

## Structure

- Shared package `glip_demo_pkg` holds:
  - the mode encodings (LOOPBACK, GEN, CHECK, GENCHECK),
  - the checker state encodings (SYNC, CHECK),
  - the LFSR tap mask constant.
- Sub-module `glip_demo_pattern_next`: combinational `next()` of one byte, with the compile option inside. It is instantiated twice, once for the generator and once for the checker.

## Test plan

- **Loopback:** mode 00, drive bytes 8'h11, 8'h22 with `out_ready = 1` → `out_data` mirrors in the same cycle. With `out_ready = 0` → `in_ready = 0`.
- **Generator with backpressure:** mode 01, `out_ready` toggling 1,0,1 → outputs 8'h01, 8'h02, 8'h03 with each byte held stable while stalled. 8'hFF is followed by 8'h00 (default build).
- **Checker, clean stream:** mode 10, send 8'h40..8'h4F → `synced = 1` after the first byte, `err_count = 0`, `error` never pulses.
- **Checker, mismatch:** mode 10, send 8'h05, 8'h06, 8'h09, 8'h0A → exactly one `error` pulse (after 8'h09), `err_count = 1`, `error_sticky = 1`, no further errors. Also: with ERRCNT_WIDTH = 2, five mismatches → `err_count = 3`.
- **Deferred mode change and reset:** mode 01 with `out_ready = 0`, switch `mode` to 10 → `out_valid` stays 1 with data unchanged until `out_ready = 1`, then mode 10 takes effect. Pulse `rstn` low mid-stream → all outputs at reset values immediately.
- **LFSR build:** `GLIP_DEMO_TRAFFIC_LFSR_EN` defined, mode 11 looped externally (out to in) → 255 distinct non-zero bytes per period, `err_count = 0`.
